// File: rtl/dpp_table_pkg.sv
// dpp_table_pkg: shared definitions for the dining-philosophers table.
//   PHILO_HUNGRY / PHILO_DONE : one-bit event words carried on the
//                               philosopher outbound FIFOs
//   table_state_t             : table arbiter states
package dpp_table_pkg;

    localparam logic PHILO_HUNGRY = 1'b1;
    localparam logic PHILO_DONE   = 1'b0;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        CHK_L = 2'd1,
        CHK_R = 2'd2
    } table_state_t;

endpackage

// File: rtl/dpp_rr_pick.sv
// dpp_rr_pick: combinational round-robin first-one finder.
//   req   in  N  request vector
//   rr    in  W  index searched first; search wraps modulo N
//   valid out 1  some request bit is set
//   idx   out W  first requesting index at or after rr (mod N)
module dpp_rr_pick #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr,
    output logic         valid,
    output logic [W-1:0] idx
);

    localparam int unsigned NU = N;

    always_comb begin
        int unsigned c;
        logic [W-1:0] ci;
        valid = 1'b0;
        idx   = '0;
        c     = 0;
        ci    = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            // explicit wrap: N need not be a power of two
            c = 32'(rr) + k;
            if (c >= NU) c = c - NU;
            ci = W'(c);
            if (!valid && req[ci]) begin
                valid = 1'b1;
                idx   = ci;
            end
        end
    end

endmodule

// File: rtl/dpp_table.sv
// dpp_table: central arbiter of the dining-philosophers design. Drains each
// philosopher's outbound event FIFO (HUNGRY / DONE), owns the fork bitmap,
// grants forks and re-offers freed forks to waiting neighbours.
//   clk        in   1        system clock
//   reset      in   1        synchronous, active-high reset
//   foutData   in   N_PHILO  head-of-FIFO event per philosopher (FWFT)
//   foutEmpty  in   N_PHILO  philosopher FIFO empty flags
//   foutAck    out  N_PHILO  one-cycle pop strobe to philosopher FIFO i
//   may_eat    out  N_PHILO  one-cycle grant pulse to philosopher i
//   eating     out  N_PHILO  philosopher i currently holds its forks
//   err        out  1        sticky protocol error
// Build option: define DPP_TABLE_ERR_EN to enable protocol checking;
// otherwise err is tied low and no checking logic exists.
module dpp_table
    import dpp_table_pkg::*;
#(
    parameter int N_PHILO = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PHILO-1:0] foutData,
    input  logic [N_PHILO-1:0] foutEmpty,
    output logic [N_PHILO-1:0] foutAck,
    output logic [N_PHILO-1:0] may_eat,
    output logic [N_PHILO-1:0] eating,
    output logic               err
);

    localparam int IDX_W = (N_PHILO > 1) ? $clog2(N_PHILO) : 1;

    function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] x);
        return (x == IDX_W'(N_PHILO - 1)) ? '0 : x + IDX_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] dec(input logic [IDX_W-1:0] x);
        return (x == '0) ? IDX_W'(N_PHILO - 1) : x - IDX_W'(1);
    endfunction

    table_state_t       state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [N_PHILO-1:0] forks_q, forks_d;
    logic [N_PHILO-1:0] hungry_q, hungry_d;
    logic [N_PHILO-1:0] eating_d, ack_d, may_eat_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx, pick_nb;
    logic               ev_hungry, ev_done, ev_bad;

    // A FIFO whose pop is still in flight keeps showing the consumed word
    // for one more cycle, so it is masked out of the request vector.
    dpp_rr_pick #(
        .N (N_PHILO),
        .W (IDX_W)
    ) u_pick (
        .req   (~foutEmpty & ~foutAck),
        .rr    (rr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign pick_nb   = inc(pick_idx);
    assign ev_hungry = (foutData[pick_idx] == PHILO_HUNGRY);
    assign ev_done   = (foutData[pick_idx] == PHILO_DONE);

`ifdef DPP_TABLE_ERR_EN
    logic err_q, err_d;

    assign ev_bad = ev_hungry ? (eating[pick_idx] | hungry_q[pick_idx])
                              : !eating[pick_idx];
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    always_comb begin
        err_d = err_q;
        if (state_q == SCAN && pick_valid && ev_bad) err_d = 1'b1;
    end
`else
    assign ev_bad = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        logic [IDX_W-1:0] side, side_nb;
        state_d   = state_q;
        rr_d      = rr_q;
        cur_d     = cur_q;
        forks_d   = forks_q;
        hungry_d  = hungry_q;
        eating_d  = eating;
        ack_d     = '0;
        may_eat_d = '0;
        side      = '0;
        side_nb   = '0;

        case (state_q)
            SCAN: begin
                if (pick_valid) begin
                    ack_d[pick_idx] = 1'b1;
                    rr_d            = pick_nb;
                    if (ev_bad) begin
                        // erroneous events are popped but change no state
                    end else if (ev_hungry) begin
                        if (!forks_q[pick_idx] && !forks_q[pick_nb]) begin
                            forks_d[pick_idx]   = 1'b1;
                            forks_d[pick_nb]    = 1'b1;
                            eating_d[pick_idx]  = 1'b1;
                            may_eat_d[pick_idx] = 1'b1;
                        end else begin
                            hungry_d[pick_idx] = 1'b1;
                        end
                    end else if (ev_done) begin
                        forks_d[pick_idx]  = 1'b0;
                        forks_d[pick_nb]   = 1'b0;
                        eating_d[pick_idx] = 1'b0;
                        cur_d              = pick_idx;
                        state_d            = CHK_L;
                    end
                end
            end
            CHK_L, CHK_R: begin
                side    = (state_q == CHK_L) ? dec(cur_q) : inc(cur_q);
                side_nb = inc(side);
                if (hungry_q[side] && !forks_q[side] && !forks_q[side_nb]) begin
                    forks_d[side]   = 1'b1;
                    forks_d[side_nb] = 1'b1;
                    eating_d[side]  = 1'b1;
                    may_eat_d[side] = 1'b1;
                    hungry_d[side]  = 1'b0;
                end
                state_d = (state_q == CHK_L) ? CHK_R : SCAN;
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SCAN;
            rr_q     <= '0;
            cur_q    <= '0;
            forks_q  <= '0;
            hungry_q <= '0;
            eating   <= '0;
            foutAck  <= '0;
            may_eat  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            cur_q    <= cur_d;
            forks_q  <= forks_d;
            hungry_q <= hungry_d;
            eating   <= eating_d;
            foutAck  <= ack_d;
            may_eat  <= may_eat_d;
        end
    end

endmodule

// File: tb/tb_dpp_table.sv
// tb_dpp_table: self-checking bench for dpp_table (N_PHILO = 5).
// Philosopher FIFOs are modelled as queues; expected pops and grants are
// queued when events are pushed and consumed when the DUT produces them.
module tb_dpp_table;

    localparam int N = 5;
    localparam logic HUNGRY = 1'b1;
    localparam logic DONE   = 1'b0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] foutData = '0;
    logic [N-1:0] foutEmpty = '1;
    logic [N-1:0] foutAck;
    logic [N-1:0] may_eat;
    logic [N-1:0] eating;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    logic fq [N][$];
    int   exp_ack[$];
    int   exp_grant[$];

    dpp_table #(.N_PHILO(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .foutData  (foutData),
        .foutEmpty (foutEmpty),
        .foutAck   (foutAck),
        .may_eat   (may_eat),
        .eating    (eating),
        .err       (err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int first_one(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // FIFO model and output scoreboard, evaluated on the falling edge.
    initial begin : monitor
        int a, e;
        forever begin
            @(negedge clk);
            if (foutAck !== '0) begin
                n_checks++;
                if (!$onehot(foutAck)) begin
                    n_fail++;
                    $display("FAIL ack_onehot: foutAck=%b, required one-hot", foutAck);
                end else begin
                    a = first_one(foutAck);
                    if (exp_ack.size() == 0) begin
                        n_fail++;
                        $display("FAIL ack_unexpected: philo %0d acked, required no ack", a);
                    end else begin
                        e = exp_ack.pop_front();
                        if (a != e) begin
                            n_fail++;
                            $display("FAIL ack_order: philo %0d acked, required %0d", a, e);
                        end
                    end
                    n_checks++;
                    if (fq[a].size() == 0) begin
                        n_fail++;
                        $display("FAIL ack_empty: philo %0d acked with 0 words queued, required >=1", a);
                    end else begin
                        void'(fq[a].pop_front());
                    end
                end
            end
            if (may_eat !== '0) begin
                n_checks++;
                if (!$onehot(may_eat)) begin
                    n_fail++;
                    $display("FAIL grant_onehot: may_eat=%b, required one-hot", may_eat);
                end else begin
                    a = first_one(may_eat);
                    if (exp_grant.size() == 0) begin
                        n_fail++;
                        $display("FAIL grant_unexpected: philo %0d granted, required no grant", a);
                    end else begin
                        e = exp_grant.pop_front();
                        if (a != e) begin
                            n_fail++;
                            $display("FAIL grant_order: philo %0d granted, required %0d", a, e);
                        end
                    end
                end
            end
            n_checks++;
            if ((eating & {eating[0], eating[N-1:1]}) !== '0) begin
                n_fail++;
                $display("FAIL adjacent_eating: eating=%b, required no adjacent pair", eating);
            end
            for (int i = 0; i < N; i++) begin
                foutEmpty[i] = (fq[i].size() == 0);
                foutData[i]  = (fq[i].size() == 0) ? 1'b0 : fq[i][0];
            end
        end
    end

    task automatic flush_model();
        for (int i = 0; i < N; i++) fq[i].delete();
        exp_ack.delete();
        exp_grant.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        flush_model();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic push_evt(input int p, input logic w);
        @(posedge clk); #2;
        fq[p].push_back(w);
    endtask

    task automatic wait_ack(input int p, output int at);
        at = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (foutAck[p] === 1'b1) begin
                at = k;
                break;
            end
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_ack.size() != 0 || exp_grant.size() != 0) && k < 30) begin
            @(negedge clk); #1;
            k++;
        end
        n_checks++;
        if (exp_ack.size() != 0 || exp_grant.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d acks and %0d grants outstanding, required 0",
                     tag, exp_ack.size(), exp_grant.size());
        end
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk); #1;
        n_checks++;
        if (foutAck !== '0) begin n_fail++; $display("FAIL reset_ack: foutAck=%b, required 00000", foutAck); end
        n_checks++;
        if (may_eat !== '0) begin n_fail++; $display("FAIL reset_may_eat: may_eat=%b, required 00000", may_eat); end
        n_checks++;
        if (eating !== '0) begin n_fail++; $display("FAIL reset_eating: eating=%b, required 00000", eating); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: err=%b, required 0", err); end
    endtask

    task automatic test_hungry_grant();
        int at;
        do_reset();
        exp_ack.push_back(0);
        exp_grant.push_back(0);
        push_evt(0, HUNGRY);
        wait_ack(0, at);
        n_checks++;
        if (at != 1) begin
            n_fail++;
            $display("FAIL hungry_ack_latency: ack seen at sample %0d, required 1", at);
        end else begin
            n_checks++;
            if (may_eat !== 5'b00001) begin n_fail++; $display("FAIL hungry_grant: may_eat=%b, required 00001", may_eat); end
            n_checks++;
            if (eating !== 5'b00001) begin n_fail++; $display("FAIL hungry_eating: eating=%b, required 00001", eating); end
        end
        drain("hungry");
    endtask

    task automatic test_neighbour_release();
        int at, d;
        do_reset();
        exp_ack.push_back(0);
        exp_ack.push_back(1);
        exp_grant.push_back(0);
        push_evt(0, HUNGRY);
        push_evt(1, HUNGRY);
        drain("neigh_setup");
        n_checks++;
        if (eating !== 5'b00001) begin n_fail++; $display("FAIL neigh_blocked: eating=%b, required 00001", eating); end
        exp_ack.push_back(0);
        exp_grant.push_back(1);
        push_evt(0, DONE);
        wait_ack(0, at);
        d = -1;
        for (int k = 1; k <= 6 && d < 0; k++) begin
            @(negedge clk); #1;
            if (may_eat[1] === 1'b1) d = k;
        end
        n_checks++;
        if (at != 1 || d != 2) begin
            n_fail++;
            $display("FAIL neigh_chk_r_latency: ack at %0d grant %0d cycles later, required 1 and 2", at, d);
        end
        drain("neigh");
        n_checks++;
        if (eating !== 5'b00010) begin n_fail++; $display("FAIL neigh_eating: eating=%b, required 00010", eating); end
    endtask

    task automatic test_wrap();
        do_reset();
        exp_ack.push_back(4);
        exp_grant.push_back(4);
        push_evt(4, HUNGRY);
        drain("wrap_setup");
        exp_ack.push_back(0);
        push_evt(0, HUNGRY);
        drain("wrap_block");
        n_checks++;
        if (eating !== 5'b10000) begin n_fail++; $display("FAIL wrap_blocked: eating=%b, required 10000", eating); end
        exp_ack.push_back(4);
        exp_grant.push_back(0);
        push_evt(4, DONE);
        drain("wrap");
        n_checks++;
        if (eating !== 5'b00001) begin n_fail++; $display("FAIL wrap_eating: eating=%b, required 00001", eating); end
    endtask

    task automatic test_all_hungry();
        int at;
        logic [N-1:0] want;
        do_reset();
        for (int i = 0; i < N; i++) exp_ack.push_back(i);
        exp_grant.push_back(0);
        exp_grant.push_back(2);
        @(posedge clk); #2;
        for (int i = 0; i < N; i++) fq[i].push_back(HUNGRY);
        wait_ack(0, at);
        n_checks++;
        if (at != 1) begin n_fail++; $display("FAIL all_first_ack: ack0 at sample %0d, required 1", at); end
        for (int k = 1; k < N; k++) begin
            @(negedge clk); #1;
            want = '0;
            want[k] = 1'b1;
            n_checks++;
            if (foutAck !== want) begin
                n_fail++;
                $display("FAIL all_pop_order: foutAck=%b, required %b", foutAck, want);
            end
        end
        drain("all");
        n_checks++;
        if (eating !== 5'b00101) begin n_fail++; $display("FAIL all_eating: eating=%b, required 00101", eating); end
    endtask

    task automatic test_reset_in_chk();
        int at;
        logic quiet;
        do_reset();
        exp_ack.push_back(0);
        exp_ack.push_back(1);
        exp_grant.push_back(0);
        push_evt(0, HUNGRY);
        push_evt(1, HUNGRY);
        drain("rst_setup");
        exp_ack.push_back(0);
        push_evt(0, DONE);
        wait_ack(0, at);
        // table is now in CHK_L; the next edge sees reset
        reset = 1'b1;
        flush_model();
        @(negedge clk); #1;
        n_checks++;
        if (foutAck !== '0 || may_eat !== '0 || eating !== '0) begin
            n_fail++;
            $display("FAIL rst_chk_outputs: ack=%b may_eat=%b eating=%b, required all 00000",
                     foutAck, may_eat, eating);
        end
        @(posedge clk); #2;
        reset = 1'b0;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk); #1;
            if (may_eat !== '0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin n_fail++; $display("FAIL rst_late_grant: may_eat pulsed after reset, required none"); end
        exp_ack.push_back(2);
        exp_grant.push_back(2);
        push_evt(2, HUNGRY);
        wait_ack(2, at);
        n_checks++;
        if (at != 1 || may_eat !== 5'b00100) begin
            n_fail++;
            $display("FAIL rst_scan_resume: ack at %0d may_eat=%b, required 1 and 00100", at, may_eat);
        end
        drain("rst");
    endtask

`ifdef DPP_TABLE_ERR_EN
    task automatic test_err();
        int at;
        do_reset();
        exp_ack.push_back(2);
        exp_grant.push_back(2);
        push_evt(2, HUNGRY);
        drain("err_setup");
        exp_ack.push_back(3);
        push_evt(3, DONE);
        wait_ack(3, at);
        n_checks++;
        if (at != 1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: ack at %0d err=%b, required 1 and 1", at, err);
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (err !== 1'b1 || eating !== 5'b00100) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b eating=%b, required 1 and 00100", err, eating);
        end
        exp_ack.push_back(3);
        push_evt(3, HUNGRY);
        drain("err_fork");
        n_checks++;
        if (eating !== 5'b00100) begin n_fail++; $display("FAIL err_fork_kept: eating=%b, required 00100", eating); end
        do_reset();
        @(negedge clk); #1;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: err=%b, required 0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_hungry_grant();
        test_neighbour_release();
        test_wrap();
        test_all_hungry();
        test_reset_in_chk();
`ifdef DPP_TABLE_ERR_EN
        test_err();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dpp_table.md
Name: dpp_table

Overview:
- Central arbiter (the "table") of the dining-philosophers design; the other end of the philosopher event protocol.
- Drains each philosopher's outbound event FIFO (HUNGRY / DONE) and owns the fork bitmap.
- Pulses may_eat to a philosopher once both of its forks are free; re-offers freed forks to hungry neighbours.
- One instance serves all N_PHILO philosophers.

Parameters:
- N_PHILO, 5, number of philosophers and forks (>=2). Philosopher i uses fork i and fork (i+1) mod N_PHILO.
- IDX_W, log2(N_PHILO), width of the philosopher index (derived; not overridden).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- foutData  in  N_PHILO  head-of-FIFO event per philosopher; first-word-fall-through, valid while foutEmpty[i]=0; `PHILO_HUNGRY=1'b1, `PHILO_DONE=1'b0
- foutEmpty  in  N_PHILO  philosopher FIFO empty flags
- foutAck  out  N_PHILO  registered one-cycle pop strobe to philosopher FIFO i
- may_eat  out  N_PHILO  registered one-cycle grant pulse to philosopher i (feeds its inbound FIFO wr_en/din)
- eating  out  N_PHILO  registered status; bit i=1 while philosopher i holds its forks
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset: foutAck=0, may_eat=0, eating=0, forks_busy=0, hungry=0, err=0, rr pointer=0, state=SCAN. Reset mid-operation discards all grants in flight; philosophers are reset by the same signal.
- Default every cycle: foutAck=0, may_eat=0 (pulses only).
- SCAN:
  - Pick the first i in round-robin order starting at rr with foutEmpty[i]=0 and foutAck[i]=0. The foutAck[i]=0 guard prevents re-reading a FIFO whose pop is still in flight.
  - If none qualifies, stay in SCAN and take no action.
  - Otherwise: sample foutData[i], set foutAck[i]=1 for the next cycle, and set rr=(i+1) mod N_PHILO.
  - HUNGRY, forks i and i+1 free: set both forks busy, set eating[i], pulse may_eat[i] in the next cycle. Stay in SCAN.
  - HUNGRY, either fork busy: set hungry[i]. Stay in SCAN.
  - DONE: clear forks i and i+1, clear eating[i], latch cur=i, go to CHK_L.
- CHK_L: L=(cur+N_PHILO-1) mod N_PHILO. If hungry[L] and forks L and L+1 are free: grant L as above and clear hungry[L]. Go to CHK_R.
- CHK_R: R=(cur+1) mod N_PHILO. Same check and grant for R. Go to SCAN.
- Timing and throughput:
  - One FIFO pop per SCAN cycle at most; a DONE costs 3 cycles.
  - Grant latency: may_eat is asserted 1 cycle after the HUNGRY word is sampled, or 1 cycle after the CHK state grants.
- Index arithmetic: modulo N_PHILO with explicit wrap; never rely on 2^IDX_W overflow. Fork (N_PHILO-1)+1 wraps to fork 0.
- At most one may_eat bit and one foutAck bit are high in any cycle.
- Invariant: adjacent eating bits are never both 1.

Optional Feature:
- DPP_TABLE_ERR_EN defined: err is set and held until reset on any of:
  - HUNGRY from a philosopher with eating[i]=1 or hungry[i]=1;
  - DONE from a philosopher with eating[i]=0.
  The offending event is still popped. An erroneous DONE changes no fork or eating state; an erroneous HUNGRY changes no hungry or eating state.
- DPP_TABLE_ERR_EN undefined: err is tied to 0, no checking logic is built, and events are applied as described above.

Decomposition:
- dpp.v (shared header) holds `PHILO_HUNGRY, `PHILO_DONE, `TRUE, `FALSE, and the table state encodings SCAN=0, CHK_L=1, CHK_R=2.
- function.v supplies log2.
- One natural sub-module: dpp_rr_pick. Combinational round-robin first-one finder taking the request vector (~foutEmpty & ~foutAck) and rr; returns valid and idx.

Test Plan:
- Reset, then philosopher 0 HUNGRY -> foutAck[0] high 1 cycle after sampling; may_eat[0] pulses 1 cycle after sampling; eating=5'b00001.
- N_PHILO=5: philos 0 then 1 HUNGRY -> philo 0 granted, philo 1 hungry (fork 1 busy); philo 0 DONE -> in CHK_R, may_eat[1] pulses and eating=5'b00010.
- Wrap: philo 4 eating, philo 0 HUNGRY -> blocked on fork 0; philo 4 DONE -> philo 0 granted in CHK_R.
- All five FIFOs non-empty with HUNGRY in the same cycle -> popped in order 0,1,2,3,4 on consecutive cycles; grants only to 0 and 2; no FIFO is acked twice for one word.
- With DPP_TABLE_ERR_EN: DONE from idle philo 3 -> err=1 and stays 1; fork state unchanged; reset clears err.
- Reset asserted during CHK_L -> next cycle all outputs 0, state SCAN, and no late may_eat pulse.
